counter_sequencer: RTL

Run/stop controller that sequences a WIDTH-bit binary up-counter datapath (the T-flip-flop ripple counter family) as a programmable interval timer. A host writes a terminal value and mode through a valid/ready config port, then starts and stops the count. The block flags terminal count and either halts (one-shot) or wraps and repeats (periodic). It sits between the control logic and the counter datapath; the counter register lives inside this block.

---
 rtl/counter_sequencer_if.sv | 28 ++
 rtl/counter_sequencer.sv | 114 +++++++++++
 2 files changed

// File: rtl/counter_sequencer_if.sv
// Host-side bundle for counter_sequencer: the config handshake, the run
// controls and the observable timer status.
interface counter_sequencer_if #(
   parameter int WIDTH = 4
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [WIDTH-1:0] cfg_limit;
   logic             cfg_periodic;
   logic             start;
   logic             stop;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             tick;
   logic             done;

   // Host side: issues config and run controls, observes status.
   modport master (
      output cfg_valid, cfg_limit, cfg_periodic, start, stop,
      input  cfg_ready, count, busy, tick, done
   );

   // Timer side: accepts config and controls, reports status.
   modport slave (
      input  cfg_valid, cfg_limit, cfg_periodic, start, stop,
      output cfg_ready, count, busy, tick, done
   );
endinterface

// File: rtl/counter_sequencer.sv
// Programmable interval timer: a run/stop sequencer wrapped around a
// WIDTH-bit up-counter. The host latches a terminal value and a mode
// (one-shot or periodic), then starts and stops the count. Terminal count
// raises a one-cycle tick and either halts in DONE or wraps back to zero.
module counter_sequencer #(
   parameter int WIDTH = 4
) (
   input logic                clk,
   input logic                rst_n,
   counter_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] limit_q;
   logic             periodic_q;

   logic             cfg_fire_s;
   logic             at_limit_s;

   // Config is only refused while counting, so the terminal value can never
   // change underneath a running interval.
   assign bus.cfg_ready = (state_q != ST_RUN);
   assign cfg_fire_s    = bus.cfg_valid && bus.cfg_ready;
   assign at_limit_s    = (count_q == limit_q);

   // Status decodes straight from registered state; tick also looks at stop
   // so that a stop on the terminal cycle suppresses the event.
   assign bus.count = count_q;
   assign bus.busy  = (state_q == ST_RUN);
   assign bus.done  = (state_q == ST_DONE);
   assign bus.tick  = (state_q == ST_RUN) && at_limit_s && !bus.stop;

   // Sequencer FSM together with the counter, limit and mode registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         count_q    <= {WIDTH{1'b0}};
         limit_q    <= {WIDTH{1'b0}};
         periodic_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // Unconfigured: start/stop have nothing to act on yet.
               if (cfg_fire_s) begin
                  limit_q    <= bus.cfg_limit;
                  periodic_q <= bus.cfg_periodic;
                  count_q    <= {WIDTH{1'b0}};
                  state_q    <= ST_ARMED;
               end else begin
                  state_q    <= ST_IDLE;
               end
            end
            ST_ARMED: begin
               if (cfg_fire_s) begin
                  limit_q    <= bus.cfg_limit;
                  periodic_q <= bus.cfg_periodic;
                  count_q    <= {WIDTH{1'b0}};
                  state_q    <= ST_ARMED;
               end else if (bus.start && !bus.stop) begin
                  count_q    <= {WIDTH{1'b0}};
                  state_q    <= ST_RUN;
               end else begin
                  state_q    <= ST_ARMED;
               end
            end
            ST_RUN: begin
               // Stop outranks terminal count: freeze where we are.
               if (bus.stop) begin
                  state_q <= ST_ARMED;
               end else if (at_limit_s) begin
                  if (periodic_q) begin
                     // Explicit clear, so a limit below all-ones wraps early
                     // and all-ones never relies on arithmetic overflow.
                     count_q <= {WIDTH{1'b0}};
                     state_q <= ST_RUN;
                  end else begin
                     state_q <= ST_DONE;
                  end
               end else begin
                  count_q <= count_q + {{(WIDTH-1){1'b0}}, 1'b1};
                  state_q <= ST_RUN;
               end
            end
            ST_DONE: begin
               // A new config takes precedence over a restart.
               if (cfg_fire_s) begin
                  limit_q    <= bus.cfg_limit;
                  periodic_q <= bus.cfg_periodic;
                  count_q    <= {WIDTH{1'b0}};
                  state_q    <= ST_ARMED;
               end else if (bus.start) begin
                  count_q    <= {WIDTH{1'b0}};
                  state_q    <= ST_RUN;
               end else begin
                  state_q    <= ST_DONE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               count_q <= {WIDTH{1'b0}};
            end
         endcase
      end
   end

endmodule
